// File: rtl/sv_deser_pkg.sv
// Shared types and helpers for the bit deserializer.
//   deser_state_t : collector FSM states
//   len_width()   : width of a field that can hold the values 0..width
//   CNT_W         : width of the completed-word counter
package sv_deser_pkg;

   typedef enum logic [1:0] {FILL, STALL, FLUSH} deser_state_t;

   localparam int unsigned CNT_W = 16;

   function automatic int unsigned len_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sv_deser_slot.sv
// Output holding register of the deserializer, with its valid/ready handshake
// and a wrapping count of completed transfers.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture load_word/load_len (only asserted while slot_free)
//   load_word        : packed word to present
//   load_len         : number of valid bits in load_word
//   slot_free        : slot empty or being emptied this cycle
//   word_out/len     : presented word and its bit count
//   word_valid       : word_out/word_len valid
//   word_ready       : consumer takes the word this cycle
//   words_out        : completed transfer count
module sv_deser_slot
   import sv_deser_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LW    = len_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_word,
   input  logic [LW-1:0]      load_len,
   output logic               slot_free,
   output logic [WIDTH-1:0]   word_out,
   output logic [LW-1:0]      word_len,
   output logic               word_valid,
   input  logic               word_ready,
   output logic [CNT_W-1:0]   words_out
);

   assign slot_free = !word_valid || word_ready;

   // A load on the same edge as a transfer keeps word_valid high: back-to-back words.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_out   <= '0;
         word_len   <= '0;
         word_valid <= 1'b0;
         words_out  <= '0;
      end else begin
         if (load) begin
            word_out   <= load_word;
            word_len   <= load_len;
            word_valid <= 1'b1;
         end else if (word_ready) begin
            word_valid <= 1'b0;
         end
         if (word_valid && word_ready) begin
            words_out <= words_out + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sv_bit_deser.sv
// Serial-to-parallel collector: packs accepted bits LSB-first into WIDTH-bit
// words; flush emits a zero-padded partial word with its bit count.
//   clk, rst              : clock, synchronous active-high reset
//   bit_in/valid/ready    : serial input handshake (bit_ready is combinational)
//   flush                 : request to emit the pending partial word
//   word_out/len/valid    : output word handshake, word_ready from the consumer
//   words_out             : completed transfer count
module sv_bit_deser
   import sv_deser_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned LW    = len_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               bit_ready,
   input  logic               flush,
   output logic [WIDTH-1:0]   word_out,
   output logic [LW-1:0]      word_len,
   output logic               word_valid,
   input  logic               word_ready,
   output logic [CNT_W-1:0]   words_out
);

   deser_state_t       state, state_d;
   logic [LW-1:0]      cnt, cnt_d, eff_cnt;
   logic [WIDTH-1:0]   sreg, sreg_d, sreg_w;
   logic               load, slot_free;
   logic [WIDTH-1:0]   load_word;
   logic [LW-1:0]      load_len;

   assign bit_ready = !rst && (state == FILL);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
         cnt   <= '0;
         sreg  <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         sreg  <= sreg_d;
      end
   end

   // Next state and slot load; sreg is cleared on every load so bits above cnt stay zero
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      sreg_d    = sreg;
      load      = 1'b0;
      load_word = sreg;
      load_len  = LW'(WIDTH);
      sreg_w    = sreg;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         if (bit_valid && (LW'(k) == cnt)) sreg_w[k] = bit_in;
      end
      eff_cnt = cnt + LW'(bit_valid);

      case (state)
         FILL: begin
            sreg_d = sreg_w;
            cnt_d  = eff_cnt;
            if (eff_cnt == LW'(WIDTH)) begin
               // Full word; a coincident flush adds nothing
               cnt_d = '0;
               if (slot_free) begin
                  load      = 1'b1;
                  load_word = sreg_w;
                  sreg_d    = '0;
               end else begin
                  state_d = STALL;
               end
            end else if (flush && (eff_cnt != '0)) begin
               if (slot_free) begin
                  load      = 1'b1;
                  load_word = sreg_w;
                  load_len  = eff_cnt;
                  cnt_d     = '0;
                  sreg_d    = '0;
               end else begin
                  state_d = FLUSH;
               end
            end
         end
         STALL: begin
            if (slot_free) begin
               load    = 1'b1;
               cnt_d   = '0;
               sreg_d  = '0;
               state_d = FILL;
            end
         end
         FLUSH: begin
            if (slot_free) begin
               load     = 1'b1;
               load_len = cnt;
               cnt_d    = '0;
               sreg_d   = '0;
               state_d  = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   sv_deser_slot #(
      .WIDTH (WIDTH),
      .LW    (LW)
   ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_word  (load_word),
      .load_len   (load_len),
      .slot_free  (slot_free),
      .word_out   (word_out),
      .word_len   (word_len),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .words_out  (words_out)
   );

endmodule

// File: tb/tb_sv_bit_deser.sv
// Bench for sv_bit_deser: directed scenarios plus randomized handshakes,
// checked every cycle against a queue-based model of pending bits and words.
module tb_sv_bit_deser;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LW    = $clog2(WIDTH + 1);

   logic               clk;
   logic               rst;
   logic               bit_in;
   logic               bit_valid;
   logic               bit_ready;
   logic               flush;
   logic [WIDTH-1:0]   word_out;
   logic [LW-1:0]      word_len;
   logic               word_valid;
   logic               word_ready;
   logic [15:0]        words_out;

   sv_bit_deser #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .flush      (flush),
      .word_out   (word_out),
      .word_len   (word_len),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .words_out  (words_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] w;
      int unsigned      len;
   } exp_word_t;

   exp_word_t   eq[$];      // words formed but not yet transferred, oldest first
   bit          pend[$];    // accepted bits not yet formed into a word
   bit          in_q[$];    // accepted bit stream
   bit          out_q[$];   // stream rebuilt from transferred words
   int unsigned model_cnt;
   int unsigned n_acc;
   int          n_vec;
   int          n_err;
   logic [WIDTH-1:0] last_word;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check model predictions mid-cycle, advance model at the edge
   task automatic step(input logic bv, input logic b, input logic fl, input logic wr, input logic r);
      logic             mready;
      logic             xfer;
      logic [WIDTH-1:0] obs_w;
      int unsigned      obs_l;
      exp_word_t        nw;
      bit_valid  = bv;
      bit_in     = b;
      flush      = fl;
      word_ready = wr;
      rst        = r;
      @(negedge clk);
      mready = !r && (eq.size() < 2);
      chk("bit_ready", 32'(bit_ready), 32'(mready));
      chk("word_valid", 32'(word_valid), 32'(eq.size() > 0));
      chk("words_out", 32'(words_out), 32'(model_cnt[15:0]));
      if (eq.size() > 0) begin
         chk("word_out", 32'(word_out), 32'(eq[0].w));
         chk("word_len", 32'(word_len), 32'(eq[0].len));
      end
      xfer  = !r && wr && (eq.size() > 0);
      obs_w = word_out;
      obs_l = 32'(word_len);
      @(posedge clk);
      if (r) begin
         eq.delete();
         pend.delete();
         model_cnt = 0;
         while (in_q.size() > out_q.size()) void'(in_q.pop_back());
      end else begin
         if (xfer) begin
            void'(eq.pop_front());
            model_cnt++;
            last_word = obs_w;
            for (int unsigned i = 0; i < obs_l && i < WIDTH; i++) out_q.push_back(obs_w[i]);
         end
         if (bv && mready) begin
            pend.push_back(b);
            in_q.push_back(b);
            n_acc++;
         end
         if ((pend.size() == WIDTH) || (fl && pend.size() > 0)) begin
            nw.w   = '0;
            nw.len = pend.size();
            for (int i = 0; i < pend.size(); i++) nw.w[i] = pend[i];
            eq.push_back(nw);
            pend.delete();
         end
      end
      #1;
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n, input logic wr);
      for (int i = 0; i < n; i++) step(1'b1, bits[i], 1'b0, wr, 1'b0);
   endtask

   initial begin
      logic [15:0] wo_before;
      int          bad;
      n_vec = 0; n_err = 0; model_cnt = 0; n_acc = 0; last_word = '0;
      bit_valid = 0; bit_in = 0; flush = 0; word_ready = 0; rst = 1;

      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_word_out", 32'(word_out), 32'h0);
      chk("rst_word_len", 32'(word_len), 32'h0);

      // 1,0,1,1,0,0,1,0 -> 0x4D, one-cycle valid
      send_bits(32'b0100_1101, 8, 1'b1);
      chk("t1_valid", 32'(word_valid), 32'h1);
      chk("t1_word", 32'(word_out), 32'h4D);
      chk("t1_len", 32'(word_len), 32'd8);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_valid_drop", 32'(word_valid), 32'h0);
      chk("t1_words_out", 32'(words_out), 32'd1);

      // Back-pressure: 0xFF held, stall after the 16th bit
      send_bits(32'h0000_00FF, 8, 1'b0);
      send_bits(32'h0000_0000, 8, 1'b0);
      chk("t2_stall", 32'(bit_ready), 32'h0);
      chk("t2_hold", 32'(word_out), 32'hFF);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_next", 32'(word_out), 32'h00);
      chk("t2_next_valid", 32'(word_valid), 32'h1);
      chk("t2_ready_back", 32'(bit_ready), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Partial flush: 1,1,0 -> 0x03 len 3
      send_bits(32'b011, 3, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t3_word", 32'(word_out), 32'h03);
      chk("t3_len", 32'(word_len), 32'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Flush with nothing pending
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_no_word", 32'(word_valid), 32'h0);

      // Flush together with the 8th bit: exactly one full word
      wo_before = words_out;
      send_bits(32'b011_0110, 7, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_len", 32'(word_len), 32'd8);
      chk("t5_word", 32'(word_out), 32'hB6);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_single", 32'(word_valid), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_count", 32'(words_out), 32'(wo_before + 16'd1));

      // Reset mid-word discards pending bits
      send_bits(32'b10111, 5, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      send_bits(32'hA5, 8, 1'b1);
      chk("t6_word", 32'(word_out), 32'hA5);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6_count", 32'(words_out), 32'd1);
      chk("t6_last", 32'(last_word), 32'hA5);

      // Full rate: bit_ready must stay high
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'(($urandom() >> 3) & 1), 1'b0, 1'b1, 1'b0);
         chk("fullrate_ready", 32'(bit_ready), 32'h1);
      end

      // Random handshakes with rare flushes and resets
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      in_q.delete();
      out_q.delete();
      n_acc = 0;
      for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
         step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
              $urandom_range(0, 1999) == 0);
      end
      chk("random_budget", 32'(n_acc >= 10000), 32'h1);

      // Drain the residue
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drained", 32'(word_valid), 32'h0);
      chk("stream_len", 32'(out_q.size()), 32'(in_q.size()));
      bad = 0;
      for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
         if (in_q[i] != out_q[i]) bad++;
      end
      chk("stream_bits", 32'(bad), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sv_bit_deser.md
# sv_bit_deser

Serial-to-parallel collector downstream of the single-bit registered logic stages in the systemverilog benchmark category. It accepts a stream of 1-bit results under a valid/ready handshake and packs them LSB-first into WIDTH-bit words. Each word is presented on a valid/ready output port. A flush request emits a partial, zero-padded word with its bit count.

## Interface
- WIDTH, 8: output word width; legal range 2..32.
- LW, $clog2(WIDTH+1): width of the length field (derived; not overridden).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is offered this cycle.
- bit_ready  output  1  block accepts bit_in this cycle.
- flush  input  1  single-cycle request to emit the pending partial word.
- word_out  output  WIDTH  packed word; bit k = k-th accepted bit.
- word_len  output  LW  number of valid bits in word_out (1..WIDTH).
- word_valid  output  1  word_out/word_len are valid.
- word_ready  input  1  consumer takes the word this cycle.
- words_out  output  16  count of completed output transfers; wraps 0xFFFF→0.

## Operation
- Internal state: shift register sreg[WIDTH], bit counter cnt (0..WIDTH-1), one output slot (word_out, word_len, word_valid).
- Bit acceptance = bit_valid && bit_ready. Word transfer = word_valid && word_ready.
- slot_free = !word_valid || word_ready.
- FSM states:
  - FILL: bit_ready=1. An accepted bit is written to sreg[cnt].
    - If cnt==WIDTH-1 and slot_free: load slot (len=WIDTH), cnt←0, stay in FILL.
    - If cnt==WIDTH-1 and not slot_free: go to STALL.
    - Otherwise: cnt←cnt+1.
  - STALL: bit_ready=0; sreg holds a complete word. On slot_free: load slot (len=WIDTH), cnt←0, go to FILL.
  - FLUSH: bit_ready=0; cnt>0 bits are pending. On slot_free: load slot with sreg bits [cnt-1:0] and zeros above, len=cnt, cnt←0, go to FILL.
- Flush rules, evaluated in FILL after this cycle's bit:
  - Effective count 0: no-op.
  - Effective count == WIDTH (flush together with the last bit): normal full word only; no extra empty word.
  - Otherwise, if slot_free: emit the partial word immediately and stay in FILL.
  - Otherwise: go to FLUSH.
- flush in STALL or FLUSH is ignored.
- sreg bits above cnt are cleared whenever a word is loaded into the slot.
- words_out increments on every word transfer.

## Timing
- Reset values: word_out=0, word_len=0, word_valid=0, words_out=0, cnt=0, state=FILL.
- bit_ready=0 while rst=1 and 1 in the first cycle after reset.
- Latency: word_valid rises on the clock edge that accepts the WIDTH-th bit, i.e. visible the following cycle. A flush has the same one-edge latency.
- word_out and word_len hold stable while word_valid && !word_ready.
- A transfer and a new load on the same edge are allowed, giving back-to-back words with no bubble.
- At full rate (bit_valid=1, word_ready=1) the block never deasserts bit_ready.
- Reset asserted mid-word or mid-stall discards all pending bits and any held word.
- bit_ready is a combinational function of state and rst only. It must not depend on bit_valid or word_ready.

## Structure
- Package sv_deser_pkg holds:
  - the typedef enum logic [1:0] {FILL, STALL, FLUSH} deser_state_t;
  - a function for the length-field width.
- Sub-module sv_deser_slot: the output holding register with its valid/ready logic and the words_out counter. It exposes load, load_word, load_len and slot_free to the parent FSM.

## Test plan
- WIDTH=8, word_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles → word_out=0x4D, word_len=8, word_valid for exactly one cycle, words_out=1.
- word_ready=0, 16 bits (eight 1s then eight 0s):
  - 0xFF is held; bit_ready drops after the 16th bit is accepted.
  - Raise word_ready → 0xFF transfers, next cycle word_out=0x00, then bit_ready=1 again.
- Bits 1,1,0 then flush → word_out=0x03, word_len=3.
- Flush with cnt=0 → no word.
- Flush on the same cycle as the 8th bit → exactly one word (len 8).
- Five bits, then rst for one cycle, then bits forming 0xA5 → single word 0xA5; no residue from the aborted word; words_out=1.
- Random bit_valid/word_ready with 10k bits → reconstructed stream matches the input, and there is no transfer while rst=1.
